// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the 386 branch-resolution stage: opcode bytes, condition codes,
// the registered result record and the 2-bit predictor counter update.
package rf80386_br_pkg;

  // Widest count path the result record can carry; the top level uses the low CNT_W bits.
  localparam int BR_ECX_MAX = 64;

  localparam logic [7:0] OP_JO             = 8'h70;
  localparam logic [7:0] OP_JNO            = 8'h71;
  localparam logic [7:0] OP_JB             = 8'h72;
  localparam logic [7:0] OP_JNB            = 8'h73;
  localparam logic [7:0] OP_JE             = 8'h74;
  localparam logic [7:0] OP_JNE            = 8'h75;
  localparam logic [7:0] OP_JBE            = 8'h76;
  localparam logic [7:0] OP_JNBE           = 8'h77;
  localparam logic [7:0] OP_JS             = 8'h78;
  localparam logic [7:0] OP_JNS            = 8'h79;
  localparam logic [7:0] OP_JP             = 8'h7A;
  localparam logic [7:0] OP_JNP            = 8'h7B;
  localparam logic [7:0] OP_JL             = 8'h7C;
  localparam logic [7:0] OP_JNL            = 8'h7D;
  localparam logic [7:0] OP_JLE            = 8'h7E;
  localparam logic [7:0] OP_JNLE           = 8'h7F;
  localparam logic [7:0] OP_JMPS           = 8'hEB;
  localparam logic [7:0] OP_LOOPNZ         = 8'hE0;
  localparam logic [7:0] OP_LOOPZ          = 8'hE1;
  localparam logic [7:0] OP_LOOP           = 8'hE2;
  localparam logic [7:0] OP_JCXZ           = 8'hE3;
  localparam logic [7:0] OP_0F_JCC_BASE    = 8'h80;

  typedef enum logic [3:0] {
    CC_O, CC_NO, CC_B, CC_AE, CC_E, CC_NE, CC_BE, CC_A,
    CC_S, CC_NS, CC_P, CC_NP, CC_L, CC_GE, CC_LE, CC_G
  } cc_e;

  typedef struct packed {
    logic                  take;
    logic [BR_ECX_MAX-1:0] ecx;
    logic                  ecx_we;
    logic                  pred;
    logic                  mispred;
  } br_result_t;

  // Saturating 2-bit counter: 00/01 predict not-taken, 10/11 predict taken.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) begin
      nxt = ctr + 2'b01;
    end else if (!taken && ctr != 2'b00) begin
      nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Handshaked request/result bundle between decode/execute, the branch-resolution stage
// and the fetch redirect logic. The stage itself connects through the slave modport.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 32,
  parameter int PC_W  = 32
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [7:0]       ir_i;
  logic             is_0f_i;
  logic             asz32_i;
  logic [CNT_W-1:0] ecx_i;
  logic             zf_i;
  logic             cf_i;
  logic             sf_i;
  logic             vf_i;
  logic             pf_i;
  logic [PC_W-1:0]  pc_i;

  logic             out_valid_o;
  logic             out_ready_i;
  logic             take_br_o;
  logic [CNT_W-1:0] ecx_o;
  logic             ecx_we_o;
  logic             pred_taken_o;
  logic             mispredict_o;

  modport master (
    output in_valid_i, ir_i, is_0f_i, asz32_i, ecx_i,
           zf_i, cf_i, sf_i, vf_i, pf_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, take_br_o, ecx_o, ecx_we_o,
           pred_taken_o, mispredict_o
  );

  modport slave (
    input  in_valid_i, ir_i, is_0f_i, asz32_i, ecx_i,
           zf_i, cf_i, sf_i, vf_i, pf_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, take_br_o, ecx_o, ecx_we_o,
           pred_taken_o, mispredict_o
  );

endinterface

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational x86 condition-code evaluator (cc + flags -> condition true).
// Kept standalone so SETcc/CMOV can reuse it.
module br_cond_eval
  import rf80386_br_pkg::*;
(
  input  cc_e  cc_i,
  input  logic zf_i,
  input  logic cf_i,
  input  logic sf_i,
  input  logic vf_i,
  input  logic pf_i,
  output logic take_o
);

  logic lt;
  assign lt = sf_i ^ vf_i;

  // Even codes test the condition, the odd code after each one is its complement.
  always_comb begin
    take_o = 1'b0;
    case (cc_i)
      CC_O:  take_o = vf_i;
      CC_NO: take_o = !vf_i;
      CC_B:  take_o = cf_i;
      CC_AE: take_o = !cf_i;
      CC_E:  take_o = zf_i;
      CC_NE: take_o = !zf_i;
      CC_BE: take_o = cf_i | zf_i;
      CC_A:  take_o = !cf_i & !zf_i;
      CC_S:  take_o = sf_i;
      CC_NS: take_o = !sf_i;
      CC_P:  take_o = pf_i;
      CC_NP: take_o = !pf_i;
      CC_L:  take_o = lt;
      CC_GE: take_o = !lt;
      CC_LE: take_o = lt | zf_i;
      CC_G:  take_o = !(lt | zf_i);
      default: take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch-resolution stage: Jcc/JMPS/LOOPcc/JCXZ decision plus count decrement.
// Define BR_PREDICT_EN to add the 2-bit predictor table and real mispredict flags.
module branch_resolve_unit
  import rf80386_br_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PRED_ENTRIES = 64,
  parameter int PC_W         = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  branch_resolve_unit_if.slave  bus
);

  if (CNT_W < 16 || CNT_W > BR_ECX_MAX) begin : g_bad_cnt_w
    $error("branch_resolve_unit: CNT_W out of range");
  end
  if (PRED_ENTRIES < 2 || (PRED_ENTRIES & (PRED_ENTRIES - 1)) != 0) begin : g_bad_pred
    $error("branch_resolve_unit: PRED_ENTRIES must be a power of 2");
  end
  if (PC_W < $clog2(PRED_ENTRIES) + 2) begin : g_bad_pc_w
    $error("branch_resolve_unit: PC_W too narrow for predictor index");
  end

  // Masks of the active count width; for CNT_W below 32 the 32-bit mask saturates to all ones.
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MASK16 = (ONE << 16) - ONE;
  localparam logic [CNT_W-1:0] MASK32 = (ONE << 32) - ONE;

  logic             in_ready;
  logic             accept;
  logic             out_valid_q;
  br_result_t       res_q;
  br_result_t       res_d;

  logic             is_loopnz, is_loopz, is_loop, is_jcxz, is_jmps;
  logic             is_jcc_short, is_jcc_near, is_loop_fam, is_cond;
  logic             cc_take;
  logic [CNT_W-1:0] cnt_mask;
  logic [CNT_W-1:0] cnt_dec;
  logic             dec_nz;
  logic             cnt_zero;
  logic             take_d;
  logic             pred_d;

  assign in_ready = !out_valid_q || bus.out_ready_i;
  assign accept   = bus.in_valid_i && in_ready;

  assign is_loopnz    = !bus.is_0f_i && (bus.ir_i == OP_LOOPNZ);
  assign is_loopz     = !bus.is_0f_i && (bus.ir_i == OP_LOOPZ);
  assign is_loop      = !bus.is_0f_i && (bus.ir_i == OP_LOOP);
  assign is_jcxz      = !bus.is_0f_i && (bus.ir_i == OP_JCXZ);
  assign is_jmps      = !bus.is_0f_i && (bus.ir_i == OP_JMPS);
  assign is_jcc_short = !bus.is_0f_i && (bus.ir_i[7:4] == OP_JO[7:4]);
  assign is_jcc_near  =  bus.is_0f_i && (bus.ir_i[7:4] == OP_0F_JCC_BASE[7:4]);
  assign is_loop_fam  = is_loopnz || is_loopz || is_loop;
  assign is_cond      = is_jcc_short || is_jcc_near || is_loop_fam || is_jcxz;

  br_cond_eval u_cond (
    .cc_i   (cc_e'(bus.ir_i[3:0])),
    .zf_i   (bus.zf_i),
    .cf_i   (bus.cf_i),
    .sf_i   (bus.sf_i),
    .vf_i   (bus.vf_i),
    .pf_i   (bus.pf_i),
    .take_o (cc_take)
  );

  // Decrement only the active CX/ECX width; bits above it pass through untouched.
  always_comb begin
    cnt_mask = bus.asz32_i ? MASK32 : MASK16;
    cnt_dec  = ((bus.ecx_i - ONE) & cnt_mask) | (bus.ecx_i & ~cnt_mask);
    dec_nz   = |(cnt_dec & cnt_mask);
    cnt_zero = ~|(bus.ecx_i & cnt_mask);
  end

  always_comb begin
    take_d = 1'b0;
    if (is_jcc_short || is_jcc_near) begin
      take_d = cc_take;
    end else if (is_loop) begin
      take_d = dec_nz;
    end else if (is_loopz) begin
      take_d = dec_nz && bus.zf_i;
    end else if (is_loopnz) begin
      take_d = dec_nz && !bus.zf_i;
    end else if (is_jcxz) begin
      take_d = cnt_zero;
    end else if (is_jmps) begin
      take_d = 1'b1;
    end
  end

`ifdef BR_PREDICT_EN
  localparam int IDX_W = $clog2(PRED_ENTRIES);

  logic [1:0]       ctr_q [PRED_ENTRIES];
  logic [IDX_W-1:0] pred_idx;
  logic             unused_pc;

  assign pred_idx  = bus.pc_i[IDX_W:1];
  assign unused_pc = ^{bus.pc_i[PC_W-1:IDX_W+1], bus.pc_i[0]};

  // JMPS is unconditional, so it never trains the table.
  always_comb begin
    pred_d = ctr_q[pred_idx][1];
    if (is_jmps) begin
      pred_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PRED_ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (accept && is_cond) begin
      ctr_q[pred_idx] <= sat_update(ctr_q[pred_idx], take_d);
    end
  end
`else
  logic unused_pc;

  assign unused_pc = ^bus.pc_i;
  assign pred_d    = 1'b0;
`endif

  always_comb begin
    res_d         = '0;
    res_d.take    = take_d;
    res_d.ecx     = BR_ECX_MAX'(is_loop_fam ? cnt_dec : bus.ecx_i);
    res_d.ecx_we  = is_loop_fam;
    res_d.pred    = pred_d;
    res_d.mispred = pred_d ^ take_d;
  end

  // A stalled result holds because in_ready is low; drain and refill can share one edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else if (in_ready) begin
      out_valid_q <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        res_q <= res_d;
      end
    end
  end

  logic unused_res_ecx;
  assign unused_res_ecx = ^res_q.ecx;

  assign bus.in_ready_o   = in_ready;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.take_br_o    = res_q.take;
  assign bus.ecx_o        = res_q.ecx[CNT_W-1:0];
  assign bus.ecx_we_o     = res_q.ecx_we;
  assign bus.pred_taken_o = res_q.pred;
  assign bus.mispredict_o = res_q.mispred;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: table of branch ops scored in order, plus backpressure,
// predictor and async-reset sequences. Predictor expectations follow BR_PREDICT_EN.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.CNT_W(32), .PC_W(32)) bus ();

  branch_resolve_unit #(
    .CNT_W        (32),
    .PRED_ENTRIES (64),
    .PC_W         (32)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0]  ir;
    logic        is0f;
    logic        asz32;
    logic [31:0] ecx;
    logic [4:0]  flg;
    logic [31:0] pc;
    logic        take;
    logic [31:0] ecxo;
    logic        we;
  } vec_t;

  typedef struct {
    logic        take;
    logic [31:0] ecx;
    logic        we;
    logic        pred;
    logic        mis;
    int          id;
  } exp_t;

  exp_t sbQueue[$];
  exp_t monExp;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[34];

`ifdef BR_PREDICT_EN
  logic [1:0] predModel[64];
`endif

  task automatic checkOutput(input string name, input int id,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s op%0d: got %h expected %h", name, id, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input logic [7:0] ir, input logic is0f, input logic asz32,
                                 input logic [31:0] ecx, input logic [4:0] flg,
                                 input logic take, input logic [31:0] ecxo, input logic we);
    vec_t v;
    v.ir = ir; v.is0f = is0f; v.asz32 = asz32; v.ecx = ecx; v.flg = flg;
    v.pc = 32'h0; v.take = take; v.ecxo = ecxo; v.we = we;
    return v;
  endfunction

  // Expected record from the vector, with the predictor model trained in accept order.
  function automatic exp_t modelOp(input vec_t v, input int id);
    exp_t e;
    logic pred;
`ifdef BR_PREDICT_EN
    logic [5:0] idx;
    logic isJmps, isCond;
    idx    = v.pc[6:1];
    isJmps = !v.is0f && v.ir == 8'hEB;
    isCond = (v.is0f && v.ir[7:4] == 4'h8) ||
             (!v.is0f && (v.ir[7:4] == 4'h7 || v.ir[7:2] == 6'b111000));
    pred = isJmps ? 1'b1 : predModel[idx][1];
    if (isCond) begin
      if (v.take && predModel[idx] != 2'b11) predModel[idx] = predModel[idx] + 2'b01;
      else if (!v.take && predModel[idx] != 2'b00) predModel[idx] = predModel[idx] - 2'b01;
    end
`else
    pred = 1'b0;
`endif
    e.take = v.take; e.ecx = v.ecxo; e.we = v.we;
    e.pred = pred; e.mis = pred ^ v.take; e.id = id;
    return e;
  endfunction

  task automatic resetModel();
`ifdef BR_PREDICT_EN
    for (int i = 0; i < 64; i++) predModel[i] = 2'b01;
`endif
  endtask

  task automatic driveInputs(input vec_t v);
    bus.in_valid_i = 1'b1;
    bus.ir_i       = v.ir;
    bus.is_0f_i    = v.is0f;
    bus.asz32_i    = v.asz32;
    bus.ecx_i      = v.ecx;
    {bus.zf_i, bus.cf_i, bus.sf_i, bus.vf_i, bus.pf_i} = v.flg;
    bus.pc_i       = v.pc;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the op.
  task automatic applyStimulus(input vec_t v, input exp_t e);
    bit accepted = 0;
    driveInputs(v);
    for (int c = 0; c < 20 && !accepted; c++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        sbQueue.push_back(e);
        accepted = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout op%0d: got in_ready=0 expected acceptance", e.id);
    end
    bus.in_valid_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
      if (sbQueue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got out_valid=1 expected no pending op");
      end else begin
        monExp = sbQueue.pop_front();
        checkOutput("take_br", monExp.id, {31'b0, bus.take_br_o}, {31'b0, monExp.take});
        checkOutput("ecx_o", monExp.id, bus.ecx_o, monExp.ecx);
        checkOutput("ecx_we", monExp.id, {31'b0, bus.ecx_we_o}, {31'b0, monExp.we});
        checkOutput("pred_taken", monExp.id, {31'b0, bus.pred_taken_o}, {31'b0, monExp.pred});
        checkOutput("mispredict", monExp.id, {31'b0, bus.mispredict_o}, {31'b0, monExp.mis});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    exp_t e;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.ir_i = 8'h0; bus.is_0f_i = 1'b0; bus.asz32_i = 1'b0; bus.ecx_i = 32'h0;
    {bus.zf_i, bus.cf_i, bus.sf_i, bus.vf_i, bus.pf_i} = 5'b0;
    bus.pc_i = 32'h0;
    resetModel();

    @(negedge clk);
    checkOutput("rst_out_valid", 0, {31'b0, bus.out_valid_o}, 32'h0);
    checkOutput("rst_take", 0, {31'b0, bus.take_br_o}, 32'h0);
    checkOutput("rst_ecx", 0, bus.ecx_o, 32'h0);
    checkOutput("rst_ecx_we", 0, {31'b0, bus.ecx_we_o}, 32'h0);
    checkOutput("rst_pred", 0, {31'b0, bus.pred_taken_o}, 32'h0);
    checkOutput("rst_mispred", 0, {31'b0, bus.mispredict_o}, 32'h0);
    checkOutput("rst_in_ready", 0, {31'b0, bus.in_ready_o}, 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // flg = {zf, cf, sf, vf, pf}
    vecs[0]  = mkVec(8'hE2, 0, 0, 32'h1234_0001, 5'b00000, 0, 32'h1234_0000, 1);
    vecs[1]  = mkVec(8'hE2, 0, 0, 32'h1234_0000, 5'b00000, 1, 32'h1234_FFFF, 1);
    vecs[2]  = mkVec(8'h8F, 1, 1, 32'h7,         5'b00100, 0, 32'h7,         0);
    vecs[3]  = mkVec(8'h8F, 1, 1, 32'h7,         5'b00110, 1, 32'h7,         0);
    vecs[4]  = mkVec(8'hE0, 0, 1, 32'h5,         5'b10000, 0, 32'h4,         1);
    vecs[5]  = mkVec(8'hE3, 0, 1, 32'h0001_0000, 5'b00000, 0, 32'h0001_0000, 0);
    vecs[6]  = mkVec(8'hE3, 0, 0, 32'h0001_0000, 5'b00000, 1, 32'h0001_0000, 0);
    vecs[7]  = mkVec(8'hE2, 0, 1, 32'h0,         5'b00000, 1, 32'hFFFF_FFFF, 1);
    vecs[8]  = mkVec(8'hE2, 0, 1, 32'h1,         5'b00000, 0, 32'h0,         1);
    vecs[9]  = mkVec(8'hE1, 0, 1, 32'h3,         5'b10000, 1, 32'h2,         1);
    vecs[10] = mkVec(8'hE1, 0, 1, 32'h3,         5'b00000, 0, 32'h2,         1);
    vecs[11] = mkVec(8'h74, 0, 1, 32'h9,         5'b10000, 1, 32'h9,         0);
    vecs[12] = mkVec(8'h75, 0, 1, 32'h9,         5'b10000, 0, 32'h9,         0);
    vecs[13] = mkVec(8'h72, 0, 1, 32'h9,         5'b01000, 1, 32'h9,         0);
    vecs[14] = mkVec(8'h76, 0, 1, 32'h9,         5'b10000, 1, 32'h9,         0);
    vecs[15] = mkVec(8'h77, 0, 1, 32'h9,         5'b00000, 1, 32'h9,         0);
    vecs[16] = mkVec(8'h78, 0, 1, 32'h9,         5'b00000, 0, 32'h9,         0);
    vecs[17] = mkVec(8'h7A, 0, 1, 32'h9,         5'b00001, 1, 32'h9,         0);
    vecs[18] = mkVec(8'h7B, 0, 1, 32'h9,         5'b00001, 0, 32'h9,         0);
    vecs[19] = mkVec(8'h7C, 0, 1, 32'h9,         5'b00100, 1, 32'h9,         0);
    vecs[20] = mkVec(8'h7D, 0, 1, 32'h9,         5'b00100, 0, 32'h9,         0);
    vecs[21] = mkVec(8'h7E, 0, 1, 32'h9,         5'b00000, 0, 32'h9,         0);
    vecs[22] = mkVec(8'h70, 0, 1, 32'h9,         5'b00010, 1, 32'h9,         0);
    vecs[23] = mkVec(8'h71, 0, 1, 32'h9,         5'b00010, 0, 32'h9,         0);
    vecs[24] = mkVec(8'h73, 0, 1, 32'h9,         5'b01000, 0, 32'h9,         0);
    vecs[25] = mkVec(8'h79, 0, 1, 32'h9,         5'b00000, 1, 32'h9,         0);
    vecs[26] = mkVec(8'hEB, 0, 1, 32'h9,         5'b00000, 1, 32'h9,         0);
    vecs[27] = mkVec(8'h74, 1, 1, 32'h9,         5'b10000, 0, 32'h9,         0);
    vecs[28] = mkVec(8'h90, 0, 1, 32'h9,         5'b00000, 0, 32'h9,         0);
    vecs[29] = mkVec(8'hE4, 0, 1, 32'h9,         5'b00000, 0, 32'h9,         0);
    vecs[30] = mkVec(8'hE0, 0, 0, 32'hABCD_0001, 5'b00000, 0, 32'hABCD_0000, 1);
    vecs[31] = mkVec(8'h87, 1, 0, 32'h9,         5'b00000, 1, 32'h9,         0);
    vecs[32] = mkVec(8'h8E, 1, 1, 32'h9,         5'b10000, 1, 32'h9,         0);
    vecs[33] = mkVec(8'h7F, 0, 1, 32'h9,         5'b00110, 1, 32'h9,         0);

    for (int i = 0; i < 34; i++) begin
      v = vecs[i];
      v.pc = 32'h1000 + 32'(i * 2);
      e = modelOp(v, i);
      applyStimulus(v, e);
    end
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: first result stalls, next op waits, then both flow at full rate.
    bus.out_ready_i = 1'b0;
    v = mkVec(8'h74, 0, 1, 32'h11, 5'b10000, 1, 32'h11, 0);
    v.pc = 32'h1100;
    e = modelOp(v, 100);
    applyStimulus(v, e);
    v = mkVec(8'hE2, 0, 1, 32'h10, 5'b00000, 1, 32'hF, 1);
    v.pc = 32'h1102;
    driveInputs(v);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 100 + k, {31'b0, bus.in_ready_o}, 32'h0);
      checkOutput("stall_out_valid", 100 + k, {31'b0, bus.out_valid_o}, 32'h1);
      checkOutput("stall_ecx", 100 + k, bus.ecx_o, 32'h11);
      checkOutput("stall_take", 100 + k, {31'b0, bus.take_br_o}, 32'h1);
      @(posedge clk);
      #1;
    end
    bus.out_ready_i = 1'b1;
    e = modelOp(v, 101);
    applyStimulus(v, e);
    checkOutput("thru_out_valid", 101, {31'b0, bus.out_valid_o}, 32'h1);
    v = mkVec(8'h75, 0, 1, 32'h22, 5'b10000, 0, 32'h22, 0);
    v.pc = 32'h1104;
    e = modelOp(v, 102);
    applyStimulus(v, e);
    repeat (3) @(posedge clk);
    #1;

    // Predictor: same pc, JE taken three times on an untouched table entry.
    for (int k = 0; k < 3; k++) begin
      v = mkVec(8'h74, 0, 1, 32'h33, 5'b10000, 1, 32'h33, 0);
      v.pc = 32'h0000_207E;
      e.take = 1'b1; e.ecx = 32'h33; e.we = 1'b0; e.id = 200 + k;
`ifdef BR_PREDICT_EN
      e.pred = (k != 0);
      e.mis  = (k == 0);
`else
      e.pred = 1'b0;
      e.mis  = 1'b1;
`endif
      applyStimulus(v, e);
    end
    repeat (3) @(posedge clk);
    #1;

    // Async reset with a stalled result pending: it must vanish immediately.
    bus.out_ready_i = 1'b0;
    v = mkVec(8'hE2, 0, 1, 32'h7, 5'b00000, 1, 32'h6, 1);
    v.pc = 32'h1200;
    e = modelOp(v, 300);
    applyStimulus(v, e);
    @(negedge clk);
    checkOutput("pre_rst_out_valid", 300, {31'b0, bus.out_valid_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 300, {31'b0, bus.out_valid_o}, 32'h0);
    checkOutput("async_rst_ecx_we", 300, {31'b0, bus.ecx_we_o}, 32'h0);
    sbQueue.delete();
    resetModel();
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    v = mkVec(8'hE3, 0, 0, 32'hFFFF_0000, 5'b00000, 1, 32'hFFFF_0000, 0);
    v.pc = 32'h1202;
    e = modelOp(v, 301);
    applyStimulus(v, e);
    checkOutput("post_rst_latency", 301, {31'b0, bus.out_valid_o}, 32'h1);

    for (int c = 0; c < 20 && sbQueue.size() != 0; c++) begin
      @(posedge clk);
    end
    @(posedge clk);
    checkOutput("sb_drain", 999, 32'(sbQueue.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
